elevator_step_decoder: RTL
==========================

# elevator_step_decoder

Monitors the 4-bit coil pattern driven onto the elevator stepper motor and decodes it back into motion information: per-step pulses, direction, absolute step position, current floor and at-floor status. Sits beside the stepper driver on the motor coil bus and feeds the elevator controller's closed-loop floor tracking. It is the read side of the coil-phase protocol the driver writes.

## Interface
- STEPS_PER_FLOOR, 512: coil steps between adjacent floor levels (≥2).
- NUM_FLOORS, 4: number of floors (≥2); floor 0 is the bottom.
- IDLE_CYCLES, 2000000: clocks without a step before motion reports idle (must exceed the driver step period of 240000).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- motor_in  in  4  coil pattern from the stepper driver, asynchronous to clk.
- fault_clr  in  1  one-cycle pulse; clears the sticky fault.
- step_pulse  out  1  one-cycle pulse per decoded step.
- step_dir  out  1  direction of the last step: 0 = up, 1 = down.
- dir_state  out  2  0 = moving up, 1 = moving down, 2 = idle (same encoding as the driver's direction input).
- position  out  clog2(NUM_FLOORS*STEPS_PER_FLOOR)  absolute step count.
- floor  out  clog2(NUM_FLOORS)  current floor index.
- at_floor  out  1  position is exactly on a floor level.
- at_limit  out  1  a step was rejected at the top or bottom limit (sticky until reversal).
- fault  out  1  sticky protocol fault.

## Operation
- Phase codes: 1001 = P0, 1010 = P1, 0110 = P2, 0101 = P3; 0000 = coils off. All other codes are illegal.
- motor_in passes through a 2-flop synchronizer; a change is acted on only when the synchronized value differs from the previous synchronized value.
- Reference phase: invalid after reset and after 0000. The first legal phase loads the reference; no step is counted.
- With a valid reference, new phase = ref+1 mod 4 → up step; ref−1 mod 4 → down step; ref+2 mod 4 → skip. The reference always reloads to the new phase.
- Up step: position+1; at top (NUM_FLOORS*STEPS_PER_FLOOR−1) it holds and sets at_limit. Down step at 0: holds and sets at_limit. A step in the opposite direction clears at_limit.
- floor/at_floor come from an internal sub-floor counter (0..STEPS_PER_FLOOR−1) plus a floor counter, with no divider. at_floor = sub-floor counter == 0.
- dir_state FSM: IDLE → UP on an up step, IDLE → DOWN on a down step, UP ↔ DOWN on an opposite step. Any step reloads the idle timer. The timer reaching IDLE_CYCLES → IDLE. 0000 → IDLE immediately.
- Without fault detection, skip and illegal codes are ignored for counting. Illegal codes invalidate the reference.

## Timing
- Reset values: step_pulse 0, step_dir 0, dir_state 2, position 0, floor 0, at_floor 1, at_limit 0, fault 0, reference invalid, idle timer 0.
- Latency: a motor_in change produces registered step_pulse/position/floor/dir_state updates 3 clk edges later (2 sync + 1 decode).
- step_pulse is exactly 1 cycle wide. Changes arriving on consecutive cycles each produce a decision.
- fault_clr in the same cycle as a new fault: the fault wins (stays 1).
- Reset mid-motion: all state returns to reset values immediately (asynchronous). Position is not retained.

## Configuration
- ELV_STEP_FAULT_EN defined: a skip (ref+2) or an illegal code sets fault. While fault=1, steps are not counted and position/floor freeze; the reference keeps tracking. fault_clr releases counting from the next legal step.
- ELV_STEP_FAULT_EN undefined: fault is tied to 0, fault_clr is unused, and skip/illegal codes are silently ignored as in Operation.

## Structure
- Shared package elevator_pkg: phase code constants (PH0..PH3, COILS_OFF), dir_state encoding constants (DIR_UP=0, DIR_DOWN=1, DIR_IDLE=2), FSM state typedef.
- Sub-module elevator_phase_sync: the 2-flop synchronizer plus change detect, emitting the synchronized code and a one-cycle change strobe.

## Test plan
Bench parameters: STEPS_PER_FLOOR=4, NUM_FLOORS=3, IDLE_CYCLES=16.
- Reset, then drive 1001 → 1010 → 0110 → 0101 → 1001, spaced 8 cycles → 4 step_pulses, step_dir=0, position=4, floor=1, at_floor=1, dir_state=0.
- After that, hold motor_in for 20 cycles → dir_state=2 at cycle 16 after the last step; position unchanged.
- From position 0 at reference P0, drive 0101 → position stays 0, at_limit=1, no underflow. A following 1001 (up step) → position=1, at_limit=0.
- Drive 1001 → 0110 (skip): with ELV_STEP_FAULT_EN, fault=1 and the following steps do not change position until fault_clr. Without the macro, fault=0 and position is unchanged by the skip.
- Drive 0000 mid-motion, then 0110 → dir_state=2, no step counted on 0110; the next 0101 counts as an up step.
- Assert rst_n low for 1 cycle at position=7 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator stepper read side: coil phase codes,
// the dir_state encoding and the direction FSM state type.
package elevator_pkg;

    localparam logic [3:0] PH0       = 4'b1001;
    localparam logic [3:0] PH1       = 4'b1010;
    localparam logic [3:0] PH2       = 4'b0110;
    localparam logic [3:0] PH3       = 4'b0101;
    localparam logic [3:0] COILS_OFF = 4'b0000;

    localparam logic [1:0] DIR_UP   = 2'd0;
    localparam logic [1:0] DIR_DOWN = 2'd1;
    localparam logic [1:0] DIR_IDLE = 2'd2;

    typedef enum logic [1:0] {
        ST_UP   = DIR_UP,
        ST_DOWN = DIR_DOWN,
        ST_IDLE = DIR_IDLE
    } dir_state_e;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } phase_t;

    // Maps a coil pattern to its phase index; coils-off and all other codes are not legal phases.
    function automatic phase_t decode_phase(input logic [3:0] code);
        phase_t p;
        p.legal = 1'b1;
        p.idx   = 2'd0;
        case (code)
            PH0:     p.idx = 2'd0;
            PH1:     p.idx = 2'd1;
            PH2:     p.idx = 2'd2;
            PH3:     p.idx = 2'd3;
            default: p.legal = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/elevator_step_decoder_if.sv
// Coil bus and decoded motion outputs between the stepper driver side (master)
// and the step decoder (slave).
interface elevator_step_decoder_if #(
    parameter int POS_W   = 11,
    parameter int FLOOR_W = 2
);
    logic [3:0]         motor_in;
    logic               fault_clr;
    logic               step_pulse;
    logic               step_dir;
    logic [1:0]         dir_state;
    logic [POS_W-1:0]   position;
    logic [FLOOR_W-1:0] floor;
    logic               at_floor;
    logic               at_limit;
    logic               fault;

    modport master (
        output motor_in, fault_clr,
        input  step_pulse, step_dir, dir_state, position, floor, at_floor, at_limit, fault
    );

    modport slave (
        input  motor_in, fault_clr,
        output step_pulse, step_dir, dir_state, position, floor, at_floor, at_limit, fault
    );
endinterface

// File: rtl/elevator_phase_sync.sv
// Brings the asynchronous coil pattern into the clk domain and strobes for one
// cycle whenever the synchronized value differs from the previous one.
module elevator_phase_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] motor_in,
    output logic [3:0] code,
    output logic       change
);
    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic [3:0] prev_q;

    // NOTE: non-blocking assignments make the three stages shift one per edge instead of collapsing into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b0000;
            sync_q <= 4'b0000;
            prev_q <= 4'b0000;
        end else begin
            meta_q <= motor_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign code   = sync_q;
    assign change = (sync_q != prev_q);
endmodule

// File: rtl/elevator_step_decoder.sv
// Decodes the stepper coil phase sequence into step pulses, direction, position and floor.
// Define ELV_STEP_FAULT_EN to flag skipped/illegal phases as a sticky fault that freezes counting.
module elevator_step_decoder
    import elevator_pkg::*;
#(
    parameter int STEPS_PER_FLOOR = 512,
    parameter int NUM_FLOORS      = 4,
    parameter int IDLE_CYCLES     = 2000000
) (
    input logic                  clk,
    input logic                  rst_n,
    elevator_step_decoder_if.slave bus
);
    localparam int POS_W   = $clog2(NUM_FLOORS * STEPS_PER_FLOOR);
    localparam int FLOOR_W = $clog2(NUM_FLOORS);
    localparam int SUB_W   = $clog2(STEPS_PER_FLOOR);
    localparam int TMR_W   = $clog2(IDLE_CYCLES + 1);

    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(NUM_FLOORS * STEPS_PER_FLOOR - 1);
    localparam logic [SUB_W-1:0] SUB_TOP  = SUB_W'(STEPS_PER_FLOOR - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(IDLE_CYCLES);

    logic [3:0]         code;
    logic               change;
    phase_t             ph;
    logic [1:0]         ref_q;
    logic               ref_valid_q;
    logic [1:0]         delta;
    logic               is_off;
    logic               is_illegal;
    logic               is_up;
    logic               is_down;
    logic               counting;
    logic               step_up;
    logic               step_down;
    logic               fault_q;
    logic [POS_W-1:0]   pos_q;
    logic [SUB_W-1:0]   sub_q;
    logic [FLOOR_W-1:0] floor_q;
    logic               at_limit_q;
    logic               step_pulse_q;
    logic               step_dir_q;
    logic [TMR_W-1:0]   timer_q;
    dir_state_e         state_q;
    dir_state_e         state_d;

    elevator_phase_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .motor_in (bus.motor_in),
        .code     (code),
        .change   (change)
    );

    // Phase distance from the reference, mod 4: 1 = up, 3 = down, 2 = skip.
    assign ph         = decode_phase(code);
    assign delta      = ph.idx - ref_q;
    assign is_off     = change && (code == COILS_OFF);
    assign is_illegal = change && !ph.legal && (code != COILS_OFF);
    assign is_up      = change && ph.legal && ref_valid_q && (delta == 2'd1);
    assign is_down    = change && ph.legal && ref_valid_q && (delta == 2'd3);

`ifdef ELV_STEP_FAULT_EN
    logic is_skip;
    assign is_skip = change && ph.legal && ref_valid_q && (delta == 2'd2);

    // A new fault outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      fault_q <= 1'b0;
        else if (is_skip || is_illegal)  fault_q <= 1'b1;
        else if (bus.fault_clr)          fault_q <= 1'b0;
    end
    assign counting = !fault_q;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = bus.fault_clr;
    assign fault_q          = 1'b0;
    assign counting         = 1'b1;
`endif

    assign step_up   = is_up && counting;
    assign step_down = is_down && counting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q       <= 2'd0;
            ref_valid_q <= 1'b0;
        end else if (is_off || is_illegal) begin
            ref_valid_q <= 1'b0;
        end else if (change && ph.legal) begin
            ref_q       <= ph.idx;
            ref_valid_q <= 1'b1;
        end
    end

    // Floor is tracked with a wrapping sub-floor counter rather than dividing the position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q        <= '0;
            sub_q        <= '0;
            floor_q      <= '0;
            at_limit_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
        end else begin
            step_pulse_q <= step_up || step_down;
            if (step_up) begin
                step_dir_q <= 1'b0;
                if (pos_q == POS_TOP) begin
                    at_limit_q <= 1'b1;
                end else begin
                    at_limit_q <= 1'b0;
                    pos_q      <= pos_q + 1'b1;
                    if (sub_q == SUB_TOP) begin
                        sub_q   <= '0;
                        floor_q <= floor_q + 1'b1;
                    end else begin
                        sub_q <= sub_q + 1'b1;
                    end
                end
            end else if (step_down) begin
                step_dir_q <= 1'b1;
                if (pos_q == '0) begin
                    at_limit_q <= 1'b1;
                end else begin
                    at_limit_q <= 1'b0;
                    pos_q      <= pos_q - 1'b1;
                    if (sub_q == '0) begin
                        sub_q   <= SUB_TOP;
                        floor_q <= floor_q - 1'b1;
                    end else begin
                        sub_q <= sub_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     timer_q <= '0;
        else if (step_up || step_down)  timer_q <= '0;
        else if (timer_q != TMR_MAX)    timer_q <= timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default first so no path through the block can infer a latch.
    always_comb begin
        state_d = state_q;
        if (is_off)                    state_d = ST_IDLE;
        else if (step_up)              state_d = ST_UP;
        else if (step_down)            state_d = ST_DOWN;
        else if (timer_q == TMR_LAST)  state_d = ST_IDLE;
    end

    assign bus.step_pulse = step_pulse_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.dir_state  = state_q;
    assign bus.position   = pos_q;
    assign bus.floor      = floor_q;
    assign bus.at_floor   = (sub_q == '0);
    assign bus.at_limit   = at_limit_q;
    assign bus.fault      = fault_q;
endmodule
